// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: controller states and divider timing.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DIV        = 2'd1,
        FETCH_PEND = 2'd2
    } pipe_state_e;

    localparam int DIV_CYCLES_DEF = 33;
    localparam int CNT_W          = 6;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline status inputs and stage-register write/clear enables.
interface pipe_ctrl_if;

    logic       ICacheBusy;
    logic       DCacheBusy;
    logic       EXE_DivStart;
    logic       EXE_IsLoad;
    logic [4:0] EXE_rt;
    logic       ID_Valid;
    logic       ID_UsesRs;
    logic       ID_UsesRt;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       EXE_Mispredict;
    logic       MEM_Exception;

    logic       PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
    logic       ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;

    // Datapath side: reports status, consumes enables.
    modport master (
        output ICacheBusy, DCacheBusy, EXE_DivStart, EXE_IsLoad, EXE_rt,
               ID_Valid, ID_UsesRs, ID_UsesRt, ID_rs, ID_rt,
               EXE_Mispredict, MEM_Exception,
        input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
               ID_Flush, EXE_Flush, MEM_Flush, WB_Flush
    );

    // Controller side.
    modport slave (
        input  ICacheBusy, DCacheBusy, EXE_DivStart, EXE_IsLoad, EXE_rt,
               ID_Valid, ID_UsesRs, ID_UsesRt, ID_rs, ID_rt,
               EXE_Mispredict, MEM_Exception,
        output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
               ID_Flush, EXE_Flush, MEM_Flush, WB_Flush
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard: ID reads a register that the load in EXE has not produced yet.
module pipe_hazard_detect (
    input  logic       id_valid,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       exe_is_load,
    input  logic [4:0] exe_rt,
    output logic       load_use
);

    logic rs_hit, rt_hit;

    assign rs_hit   = id_uses_rs && (id_rs == exe_rt);
    assign rt_hit   = id_uses_rt && (id_rt == exe_rt);
    // $zero is never a real dependency.
    assign load_use = id_valid && exe_is_load && (exe_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: freeze, exception, mispredict, divide stall,
// load-use stall and I-cache bubble, in that priority order.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  pif
);

    pipe_state_e      state, state_nxt;
    logic [CNT_W-1:0] div_cnt, cnt_nxt;
    logic             pend_flush, pend_nxt;
    logic             load_use;

    logic pc_wr, id_wr, exe_wr, mem_wr, wb_wr;
    logic id_fl, exe_fl, mem_fl, wb_fl;

    pipe_hazard_detect u_hazard (
        .id_valid    (pif.ID_Valid),
        .id_uses_rs  (pif.ID_UsesRs),
        .id_uses_rt  (pif.ID_UsesRt),
        .id_rs       (pif.ID_rs),
        .id_rt       (pif.ID_rt),
        .exe_is_load (pif.EXE_IsLoad),
        .exe_rt      (pif.EXE_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            div_cnt    <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= cnt_nxt;
            pend_flush <= pend_nxt;
        end
    end

    always_comb begin
        pc_wr = 1'b1; id_wr = 1'b1; exe_wr = 1'b1; mem_wr = 1'b1; wb_wr = 1'b1;
        id_fl = 1'b0; exe_fl = 1'b0; mem_fl = 1'b0; wb_fl = 1'b0;
        state_nxt = state;
        cnt_nxt   = div_cnt;
        pend_nxt  = pend_flush;

        if (rst) begin
            pc_wr = 1'b0; id_wr = 1'b0; exe_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
            id_fl = 1'b1; exe_fl = 1'b1; mem_fl = 1'b1; wb_fl = 1'b1;
        end else if (pif.DCacheBusy) begin
            pc_wr = 1'b0; id_wr = 1'b0; exe_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        end else if (pif.MEM_Exception) begin
            id_fl = 1'b1; exe_fl = 1'b1; mem_fl = 1'b1;
            cnt_nxt   = '0;
            pend_nxt  = pif.ICacheBusy;
            state_nxt = pif.ICacheBusy ? FETCH_PEND : RUN;
        end else if (pif.EXE_Mispredict) begin
            cnt_nxt = '0;
            // Busy fetch: the wrong-path drop is deferred until the fetch returns.
            if (pif.ICacheBusy) begin
                pc_wr = 1'b0; id_wr = 1'b0;
                pend_nxt  = 1'b1;
                state_nxt = FETCH_PEND;
            end else begin
                id_fl     = 1'b1;
                pend_nxt  = 1'b0;
                state_nxt = RUN;
            end
        end else begin
            case (state)
                FETCH_PEND: begin
                    if (pif.ICacheBusy) begin
                        pc_wr = 1'b0; id_wr = 1'b0;
                    end else begin
                        id_fl     = pend_flush;
                        pend_nxt  = 1'b0;
                        state_nxt = RUN;
                    end
                end
                DIV: begin
                    pc_wr = 1'b0; id_wr = 1'b0; exe_wr = 1'b0; mem_fl = 1'b1;
                    cnt_nxt = div_cnt - 1'b1;
                    if (div_cnt <= CNT_W'(1)) state_nxt = RUN;
                end
                default: begin
                    if (pif.EXE_DivStart) begin
                        pc_wr = 1'b0; id_wr = 1'b0; exe_wr = 1'b0; mem_fl = 1'b1;
                        cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                        state_nxt = DIV;
                    end else if (load_use) begin
                        pc_wr = 1'b0; id_wr = 1'b0; exe_fl = 1'b1;
                    end else if (pif.ICacheBusy) begin
                        pc_wr = 1'b0; id_fl = 1'b1;
                    end
                end
            endcase
        end
    end

    assign pif.PC_Wr     = pc_wr;
    assign pif.ID_Wr     = id_wr;
    assign pif.EXE_Wr    = exe_wr;
    assign pif.MEM_Wr    = mem_wr;
    assign pif.WB_Wr     = wb_wr;
    assign pif.ID_Flush  = id_fl;
    assign pif.EXE_Flush = exe_fl;
    assign pif.MEM_Flush = mem_fl;
    assign pif.WB_Flush  = wb_fl;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus randomized traffic.
module tb_pipe_ctrl;

    localparam int DIVC = 33;

    typedef struct packed {
        logic       rst, icb, dcb, divs, isload;
        logic [4:0] exe_rt;
        logic       idv, urs, urt;
        logic [4:0] rs, rt;
        logic       mis, exc;
    } stim_t;

    typedef struct {
        logic [8:0] exp;
        string      tag;
        bit         use_snap;
        logic [8:0] snap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if pif ();

    pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining divide-stall cycles and a pending fetch redirect.
    int m_div_left = 0;
    bit m_pend     = 1'b0;

    function automatic logic [8:0] outs();
        return {pif.PC_Wr, pif.ID_Wr, pif.EXE_Wr, pif.MEM_Wr, pif.WB_Wr,
                pif.ID_Flush, pif.EXE_Flush, pif.MEM_Flush, pif.WB_Flush};
    endfunction

    task automatic model_step(input stim_t s, output logic [8:0] e);
        logic [4:0] wr;
        logic [3:0] fl;
        bit         hazard;
        wr = 5'b11111;
        fl = 4'b0000;
        hazard = s.idv && s.isload && (s.exe_rt != 0) &&
                 ((s.urs && s.rs == s.exe_rt) || (s.urt && s.rt == s.exe_rt));
        if (s.rst) begin
            wr = 5'b00000; fl = 4'b1111; m_div_left = 0; m_pend = 1'b0;
        end else if (s.dcb) begin
            wr = 5'b00000;
        end else if (s.exc) begin
            fl = 4'b1110; m_div_left = 0; m_pend = s.icb;
        end else if (s.mis) begin
            m_div_left = 0;
            if (s.icb) begin wr[4] = 1'b0; wr[3] = 1'b0; m_pend = 1'b1; end
            else begin fl[3] = 1'b1; m_pend = 1'b0; end
        end else if (m_pend) begin
            if (s.icb) begin wr[4] = 1'b0; wr[3] = 1'b0; end
            else begin fl[3] = 1'b1; m_pend = 1'b0; end
        end else if (m_div_left > 0) begin
            wr[4:2] = 3'b000; fl[1] = 1'b1; m_div_left--;
        end else if (s.divs) begin
            wr[4:2] = 3'b000; fl[1] = 1'b1; m_div_left = DIVC - 1;
        end else if (hazard) begin
            wr[4] = 1'b0; wr[3] = 1'b0; fl[2] = 1'b1;
        end else if (s.icb) begin
            wr[4] = 1'b0; fl[3] = 1'b1;
        end
        e = {wr, fl};
    endtask

    task automatic apply(input stim_t s);
        rst                = s.rst;
        pif.ICacheBusy     = s.icb;
        pif.DCacheBusy     = s.dcb;
        pif.EXE_DivStart   = s.divs;
        pif.EXE_IsLoad     = s.isload;
        pif.EXE_rt         = s.exe_rt;
        pif.ID_Valid       = s.idv;
        pif.ID_UsesRs      = s.urs;
        pif.ID_UsesRt      = s.urt;
        pif.ID_rs          = s.rs;
        pif.ID_rt          = s.rt;
        pif.EXE_Mispredict = s.mis;
        pif.MEM_Exception  = s.exc;
    endtask

    task automatic cycle(input stim_t s, input string tag);
        exp_t       x;
        logic [8:0] e;
        @(posedge clk);
        #1;
        apply(s);
        model_step(s, e);
        x.exp = e; x.tag = tag; x.use_snap = 1'b0; x.snap = '0;
        q.push_back(x);
    endtask

    // Raise rst between edges and capture outputs before any clock edge.
    task automatic async_rst(input stim_t s, input string tag);
        exp_t       x;
        logic [8:0] e;
        stim_t      r;
        @(posedge clk);
        #1;
        apply(s);
        #1;
        rst = 1'b1;
        #1;
        x.snap = outs();
        r = s; r.rst = 1'b1;
        model_step(r, e);
        x.exp = e; x.tag = tag; x.use_snap = 1'b1;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       x;
            logic [8:0] act;
            x   = q.pop_front();
            act = outs();
            checks++;
            if (act !== x.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b (PC ID EXE MEM WB | IDF EXEF MEMF WBF)", x.tag, act, x.exp);
            end
            if (x.use_snap) begin
                checks++;
                if (x.snap !== x.exp) begin
                    errors++;
                    $display("FAIL %s_async: got %b expected %b", x.tag, x.snap, x.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t z, s;
        z = '0;
        apply('0);
        rst = 1'b1;

        s = z; s.rst = 1'b1;
        cycle(s, "reset"); cycle(s, "reset");
        cycle(z, "idle");

        s = z; s.isload = 1'b1; s.exe_rt = 5'd5; s.idv = 1'b1; s.urs = 1'b1; s.rs = 5'd5;
        cycle(s, "load_use");
        cycle(z, "after_load_use");
        s.exe_rt = 5'd0; s.rs = 5'd0;
        cycle(s, "load_use_rt0");

        s = z; s.divs = 1'b1;
        for (int i = 0; i < DIVC; i++) cycle(s, "div_stall");
        cycle(z, "div_release");
        cycle(z, "div_after");

        s = z; s.mis = 1'b1; s.icb = 1'b1;
        cycle(s, "mispred_busy");
        s.mis = 1'b0;
        for (int i = 0; i < 3; i++) cycle(s, "fetch_pend_busy");
        cycle(z, "fetch_pend_flush");
        cycle(z, "fetch_pend_after");

        s = z; s.divs = 1'b1;
        for (int i = 0; i < 9; i++) cycle(s, "div_pre_exc");
        s.exc = 1'b1;
        cycle(s, "div_exception");
        s = z;
        cycle(s, "after_exc"); cycle(s, "after_exc2");

        s = z; s.dcb = 1'b1; s.mis = 1'b1;
        for (int i = 0; i < 3; i++) cycle(s, "freeze_mispred");
        s.dcb = 1'b0;
        cycle(s, "mispred_after_freeze");
        cycle(z, "idle2");

        s = z; s.divs = 1'b1;
        for (int i = 0; i < 5; i++) cycle(s, "div_pre_rst");
        async_rst(s, "rst_mid_div");
        s = z; s.rst = 1'b1;
        cycle(s, "rst_hold");
        cycle(z, "after_rst_div"); cycle(z, "after_rst_div2");

        s = z; s.mis = 1'b1; s.icb = 1'b1;
        cycle(s, "mispred_busy2");
        s.mis = 1'b0;
        cycle(s, "fetch_pend_busy2");
        async_rst(s, "rst_mid_pend");
        s = z; s.rst = 1'b1;
        cycle(s, "rst_hold2");
        cycle(z, "after_rst_pend");

        for (int n = 0; n < 3000; n++) begin
            s        = z;
            s.dcb    = ($urandom_range(0, 99) < 10);
            s.exc    = ($urandom_range(0, 99) < 3);
            s.mis    = ($urandom_range(0, 99) < 8);
            s.divs   = ($urandom_range(0, 99) < 5);
            s.icb    = ($urandom_range(0, 99) < 25);
            s.isload = ($urandom_range(0, 99) < 40);
            s.exe_rt = 5'($urandom_range(0, 5));
            s.idv    = ($urandom_range(0, 99) < 85);
            s.urs    = 1'($urandom);
            s.urt    = 1'($urandom);
            s.rs     = 5'($urandom_range(0, 5));
            s.rt     = 5'($urandom_range(0, 5));
            cycle(s, "random");
        end

        cycle(z, "final");
        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
